// File: rtl/cond_pkg.sv
// Shared encodings for the conditional-execution unit: ARM condition codes,
// flag bit positions and IT sequencer states.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator over the N,Z,C,V flag nibble.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       ex
);

  logic n, z, c, v;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ex = 1'b0;
    unique case (cond)
      COND_EQ: ex = z;
      COND_NE: ex = ~z;
      COND_CS: ex = c;
      COND_CC: ex = ~c;
      COND_MI: ex = n;
      COND_PL: ex = ~n;
      COND_VS: ex = v;
      COND_VC: ex = ~v;
      COND_HI: ex = c & ~z;
      COND_LS: ex = ~c | z;
      COND_GE: ex = ~(n ^ v);
      COND_LT: ex = n ^ v;
      COND_GT: ex = ~z & ~(n ^ v);
      COND_LE: ex = z | (n ^ v);
      COND_AL: ex = 1'b1;
      COND_NV: ex = 1'b0;
      default: ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit: flag register, registered CondEx, write gating and
// an optional IT-block sequencer built only when COND_IT_EN is defined.
module cond_unit_it
  import cond_pkg::*;
#(
  parameter int unsigned FLAG_W    = 4,
  parameter int unsigned FLAGW_GRP = 2,
  parameter int unsigned IT_MAX    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   Cond,
  input  logic [FLAG_W-1:0]            ALUFlags,
  input  logic [FLAGW_GRP-1:0]         FlagW,
  input  logic                         CondLatch,
  input  logic                         FlagLatch,
  input  logic                         PCS,
  input  logic                         NextPC,
  input  logic                         RegW,
  input  logic                         MemW,
  input  logic                         InstrDone,
  input  logic                         ITStart,
  input  logic [3:0]                   ITCond,
  input  logic [IT_MAX-1:0]            ITMask,
  input  logic [$clog2(IT_MAX+1)-1:0]  ITLen,
  output logic                         PCWrite,
  output logic                         RegWrite,
  output logic                         MemWrite,
  output logic [FLAG_W-1:0]            Flags,
  output logic                         CondExQ,
  output logic                         ITActive,
  output logic [$clog2(IT_MAX+1)-1:0]  ITRemain,
  output logic                         ITErr
);

  localparam int unsigned LW = $clog2(IT_MAX + 1);
  localparam int unsigned GW = FLAG_W / FLAGW_GRP;
  localparam logic [LW-1:0] IT_MAX_L = LW'(IT_MAX);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_ex_q, cond_ex_d;
  logic [3:0]        eff_cond;
  logic              ex;

  cond_eval u_cond_eval (
    .cond  (eff_cond),
    .flags (flags_q[3:0]),
    .ex    (ex)
  );

  // Evaluation sees pre-write flags because both registers update on the same edge.
  always_comb begin
    flags_d = flags_q;
    for (int g = 0; g < int'(FLAGW_GRP); g++) begin
      if (FlagLatch && FlagW[g] && cond_ex_q) begin
        flags_d[g*GW +: GW] = ALUFlags[g*GW +: GW];
      end
    end
    cond_ex_d = CondLatch ? ex : cond_ex_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign Flags    = flags_q;
  assign CondExQ  = cond_ex_q;
  assign MemWrite = cond_ex_q & MemW;
  assign RegWrite = cond_ex_q & RegW;
  assign PCWrite  = NextPC | (PCS & cond_ex_q);

`ifdef COND_IT_EN
  it_state_e         state_q, state_d;
  logic [IT_MAX-1:0] mask_q, mask_d;
  logic [3:0]        it_cond_q, it_cond_d;
  logic [LW-1:0]     remain_q, remain_d;
  logic              err_q, err_d;

  // Else slots invert the low condition bit, which flips each code to its complement.
  assign eff_cond = (state_q == IT_ACTIVE) ? {it_cond_q[3:1], it_cond_q[0] ^ ~mask_q[0]} : Cond;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    it_cond_d = it_cond_q;
    remain_d  = remain_q;
    err_d     = err_q;
    case (state_q)
      IT_IDLE: begin
        if (ITStart) begin
          if (ITLen != '0 && ITLen <= IT_MAX_L) begin
            state_d   = IT_ACTIVE;
            mask_d    = ITMask;
            it_cond_d = ITCond;
            remain_d  = ITLen;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      IT_ACTIVE: begin
        if (ITStart) begin
          err_d = 1'b1;
        end
        if (InstrDone) begin
          if (PCS && cond_ex_q) begin
            state_d  = IT_IDLE;
            remain_d = '0;
          end else begin
            mask_d   = mask_q >> 1;
            remain_d = remain_q - LW'(1);
            if (remain_q == LW'(1)) begin
              state_d = IT_IDLE;
            end
          end
        end
      end
      default: state_d = IT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IT_IDLE;
      mask_q    <= '0;
      it_cond_q <= '0;
      remain_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      it_cond_q <= it_cond_d;
      remain_q  <= remain_d;
      err_q     <= err_d;
    end
  end

  assign ITActive = (state_q == IT_ACTIVE);
  assign ITRemain = remain_q;
  assign ITErr    = err_q;
`else
  logic unused_it;
  assign unused_it = ^{ITStart, ITCond, ITMask, ITLen, InstrDone};
  assign eff_cond  = Cond;
  assign ITActive  = 1'b0;
  assign ITRemain  = '0;
  assign ITErr     = 1'b0;
`endif

endmodule

// File: tb/tb_cond_unit_it.sv
// Self-checking bench for cond_unit_it: directed scenarios then random traffic,
// all compared against a queue-based behavioural model.
module tb_cond_unit_it;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, ITCond, ITMask;
  logic [1:0] FlagW;
  logic       CondLatch, FlagLatch, PCS, NextPC, RegW, MemW, InstrDone, ITStart;
  logic [2:0] ITLen;
  logic       PCWrite, RegWrite, MemWrite, CondExQ, ITActive, ITErr;
  logic [3:0] Flags;
  logic [2:0] ITRemain;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cond_unit_it dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .CondLatch (CondLatch),
    .FlagLatch (FlagLatch),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .InstrDone (InstrDone),
    .ITStart   (ITStart),
    .ITCond    (ITCond),
    .ITMask    (ITMask),
    .ITLen     (ITLen),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .Flags     (Flags),
    .CondExQ   (CondExQ),
    .ITActive  (ITActive),
    .ITRemain  (ITRemain),
    .ITErr     (ITErr)
  );

  // Reference model state
  logic [3:0] m_flags;
  bit         m_cex;
  bit         m_active;
  bit         m_slots[$];
  logic [3:0] m_itcond;
  bit         m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit arm_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;
      1: return !z;
      2: return cy;
      3: return !cy;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cy && !z;
      9: return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_cond();
    logic [3:0] c;
    c = Cond;
`ifdef COND_IT_EN
    if (m_active) c = {m_itcond[3:1], m_slots[0] ? m_itcond[0] : ~m_itcond[0]};
`endif
    return c;
  endfunction

  task automatic model_reset();
    m_flags = 4'h0; m_cex = 0; m_active = 0; m_itcond = 4'h0; m_err = 0;
    m_slots.delete();
  endtask

  task automatic model_update();
    bit ex;
    if (!reset) begin
      model_reset();
      return;
    end
    ex = arm_cond(model_cond(), m_flags);
    if (FlagLatch && m_cex && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    if (FlagLatch && m_cex && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
`ifdef COND_IT_EN
    if (!m_active) begin
      if (ITStart) begin
        if (ITLen >= 1 && ITLen <= 4) begin
          m_slots.delete();
          for (int i = 0; i < int'(ITLen); i++) m_slots.push_back(ITMask[i]);
          m_itcond = ITCond;
          m_active = 1;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      if (ITStart) m_err = 1;
      if (InstrDone) begin
        if (PCS && m_cex) m_slots.delete();
        else void'(m_slots.pop_front());
        if (m_slots.size() == 0) m_active = 0;
      end
    end
`endif
    if (CondLatch) m_cex = ex;
  endtask

  task automatic idle_inputs();
    reset = 1; Cond = 4'hE; ALUFlags = 0; FlagW = 0; CondLatch = 0; FlagLatch = 0;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0; InstrDone = 0; ITStart = 0;
    ITCond = 0; ITMask = 0; ITLen = 0;
  endtask

  // Inputs are already applied; compare all outputs, then clock and advance the model.
  task automatic step();
    #1;
    check_eq("flags", Flags, m_flags);
    check_eq("condexq", CondExQ, m_cex);
    check_eq("pcwrite", PCWrite, NextPC | (PCS & m_cex));
    check_eq("regwrite", RegWrite, RegW & m_cex);
    check_eq("memwrite", MemWrite, MemW & m_cex);
    check_eq("itactive", ITActive, m_active);
    check_eq("itremain", ITRemain, 3'(m_slots.size()));
    check_eq("iterr", ITErr, m_err);
    @(posedge clk);
    model_update();
    #1;
  endtask

  bit exp_slot[3];

  initial begin
    idle_inputs();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset behaviour of the write gates
    reset = 0; NextPC = 1; MemW = 1; RegW = 1;
    #1;
    check_eq("rst_pcwrite", PCWrite, 1'b1);
    check_eq("rst_regwrite", RegWrite, 1'b0);
    check_eq("rst_memwrite", MemWrite, 1'b0);
    check_eq("rst_flags", Flags, 4'b0000);
    step();

    // AL latch, then flag write, then EQ
    idle_inputs(); Cond = 4'b1110; CondLatch = 1; step();
    idle_inputs(); ALUFlags = 4'b0100; FlagW = 2'b11; FlagLatch = 1; step();
    check_eq("flags_0100", Flags, 4'b0100);
    idle_inputs(); Cond = 4'b0000; CondLatch = 1; step();
    check_eq("eq_taken", CondExQ, 1'b1);
    idle_inputs(); RegW = 1; #1;
    check_eq("eq_regwrite", RegWrite, 1'b1);
    step();

    // NE fails: flag write suppressed, branch suppressed
    idle_inputs(); Cond = 4'b0001; CondLatch = 1; step();
    check_eq("ne_not_taken", CondExQ, 1'b0);
    idle_inputs(); FlagW = 2'b11; ALUFlags = 4'b1000; FlagLatch = 1; PCS = 1; #1;
    check_eq("ne_pcwrite", PCWrite, 1'b0);
    step();
    check_eq("ne_flags_hold", Flags, 4'b0100);

    // Partial group write
    idle_inputs(); Cond = 4'b1110; CondLatch = 1; step();
    idle_inputs(); FlagW = 2'b11; ALUFlags = 4'b0010; FlagLatch = 1; step();
    check_eq("flags_0010", Flags, 4'b0010);
    idle_inputs(); FlagW = 2'b01; ALUFlags = 4'b1101; FlagLatch = 1; step();
    check_eq("grp0_only", Flags, 4'b0001);

    // IT block: EQ then/else/then with Z set
    idle_inputs(); FlagW = 2'b11; ALUFlags = 4'b0100; FlagLatch = 1; step();
    idle_inputs(); ITStart = 1; ITCond = 4'b0000; ITMask = 4'b0101; ITLen = 3; step();
`ifdef COND_IT_EN
    check_eq("it_active", ITActive, 1'b1);
    check_eq("it_remain", ITRemain, 3'd3);
    exp_slot = '{1'b1, 1'b0, 1'b1};
`else
    check_eq("it_active", ITActive, 1'b0);
    check_eq("it_remain", ITRemain, 3'd0);
    exp_slot = '{1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); Cond = 4'b1110; CondLatch = 1; step();
      check_eq($sformatf("it_slot%0d", i), CondExQ, exp_slot[i]);
      idle_inputs(); InstrDone = 1; step();
    end
    check_eq("it_done", ITActive, 1'b0);

    // Illegal length, then reset clears the sticky error
    idle_inputs(); ITStart = 1; ITLen = 0; step();
`ifdef COND_IT_EN
    check_eq("it_err_set", ITErr, 1'b1);
`else
    check_eq("it_err_set", ITErr, 1'b0);
`endif
    check_eq("it_err_idle", ITActive, 1'b0);
    idle_inputs(); reset = 0; step();
    check_eq("it_err_clr", ITErr, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) != 0);
      Cond      = 4'($urandom);
      ALUFlags  = 4'($urandom);
      FlagW     = 2'($urandom);
      CondLatch = 1'($urandom);
      FlagLatch = 1'($urandom);
      PCS       = ($urandom_range(0, 3) == 0);
      NextPC    = ($urandom_range(0, 3) == 0);
      RegW      = 1'($urandom);
      MemW      = 1'($urandom);
      InstrDone = ($urandom_range(0, 2) == 0);
      ITStart   = ($urandom_range(0, 7) == 0);
      ITCond    = 4'($urandom);
      ITMask    = 4'($urandom);
      ITLen     = 3'($urandom_range(0, 5));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
